// File: rtl/ble_cmd_sequencer_pkg.sv
// Shared types and frame geometry for the BLE command sequencer.
// Build option: BLE_CMD_SEQ_PARITY_EN adds an even-parity bit to every frame.
package ble_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} seq_state_t;

`ifdef BLE_CMD_SEQ_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int DATA_W_DEF = 8;
    localparam int FRAME_BITS = DATA_W_DEF + 2 + PAR_BITS;

    // Frame length (start + data + optional parity + stop) for any data width.
    function automatic int frame_bits(input int data_w);
        return data_w + 2 + PAR_BITS;
    endfunction

endpackage

// File: rtl/ble_cmd_fifo.sv
// Command queue: DEPTH x DATA_W storage with registered head read, flush and
// a sticky overflow flag.
module ble_cmd_fifo
    import ble_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovfl_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] head_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovfl_q;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovfl_q   <= 1'b0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
            ovfl_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A write against a full queue is lost even if a pop frees a slot.
            if (push_i && full_o) ovfl_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wr_ptr_q] <= push_data_i;
        head_q <= mem_q[rd_ptr_q];
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign ovfl_o  = ovfl_q;

endmodule

// File: rtl/ble_cmd_sequencer.sv
// Queued UART command source: serialises FIFO entries LSB first with an idle gap.
// Build option: BLE_CMD_SEQ_PARITY_EN inserts an even-parity bit before stop.
module ble_cmd_sequencer
    import ble_seq_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 2604,
    parameter int GAP_CYC  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       flush,
    input  logic                       enable,
    output logic                       TX,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       cmd_sent,
    output logic                       ovfl
);

    localparam int FB     = frame_bits(DATA_W);
    localparam int SH_W   = FB - 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(FB + 1);
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    seq_state_t        state_q, state_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              tx_q, tx_d;
    logic              sent_q, sent_d;
    logic              busy_q;
    logic              pop;
    logic [DATA_W-1:0] head;

    ble_cmd_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (wr_en),
        .push_data_i(wr_data),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_o     (head),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .ovfl_o     (ovfl)
    );

    assign pop = (state_q == IDLE) && !empty && enable && !flush;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        sent_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) state_d = LOAD;
            end
            LOAD: begin
                // The start bit goes straight to the TX flop; the shifter holds the rest.
`ifdef BLE_CMD_SEQ_PARITY_EN
                shift_d = {1'b1, ^head, head};
`else
                shift_d = {1'b1, head};
`endif
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (baud_q == BAUD_W'(BAUD_DIV - 1)) begin
                    baud_d  = '0;
                    bit_d   = bit_q + 1'b1;
                    tx_d    = shift_q[0];
                    shift_d = {1'b1, shift_q[SH_W-1:1]};
                    if (bit_q == BIT_W'(FB - 1)) begin
                        tx_d    = 1'b1;
                        sent_d  = 1'b1;
                        gap_d   = '0;
                        state_d = (GAP_CYC > 0) ? GAP : IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            GAP: begin
                tx_d = 1'b1;
                if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
                else                              gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            tx_q    <= 1'b1;
            sent_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            sent_q  <= sent_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign TX       = tx_q;
    assign cmd_sent = sent_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ble_cmd_sequencer.sv
// Scoreboard bench for ble_cmd_sequencer: stimulus queues expected bytes and a
// UART monitor decodes TX frames and checks them in order.
module tb_ble_cmd_sequencer;
    import ble_seq_pkg::*;

    localparam int BD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT0: GAP_CYC = 0
    logic       rst_n, wr_en, flush, enable;
    logic [7:0] wr_data;
    logic       tx, full, empty, busy, cmd_sent, ovfl;
    logic [2:0] count;

    // DUT1: GAP_CYC = 100
    logic       rst1_n, wr1_en, flush1, en1;
    logic [7:0] wr1_data;
    logic       tx1, full1, empty1, busy1, cmd_sent1, ovfl1;
    logic [2:0] count1;

    ble_cmd_sequencer #(.DATA_W(8), .DEPTH(4), .BAUD_DIV(BD), .GAP_CYC(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .enable(enable), .TX(tx), .full(full), .empty(empty), .count(count),
        .busy(busy), .cmd_sent(cmd_sent), .ovfl(ovfl)
    );

    ble_cmd_sequencer #(.DATA_W(8), .DEPTH(4), .BAUD_DIV(BD), .GAP_CYC(100)) dut_gap (
        .clk(clk), .rst_n(rst1_n), .wr_en(wr1_en), .wr_data(wr1_data), .flush(flush1),
        .enable(en1), .TX(tx1), .full(full1), .empty(empty1), .count(count1),
        .busy(busy1), .cmd_sent(cmd_sent1), .ovfl(ovfl1)
    );

    int errors = 0;
    int checks = 0;
    int sent_cnt = 0;
    logic [7:0] exp_q[$];
    logic prev_tx = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    always @(negedge clk) if (cmd_sent === 1'b1) sent_cnt++;

    // Monitor: mid-bit sampling of DUT0 TX, compare against scoreboard queue.
    initial begin : monitor
        logic [7:0] d;
        logic       st, sp, par;
        bit         abort;
        forever begin
            @(negedge clk);
            if (rst_n && prev_tx && !tx) begin
                abort = 0;
                par   = 1'b0;
                repeat (BD/2) begin @(negedge clk); if (!rst_n) abort = 1; end
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) begin @(negedge clk); if (!rst_n) abort = 1; end
                    d[i] = tx;
                end
`ifdef BLE_CMD_SEQ_PARITY_EN
                repeat (BD) begin @(negedge clk); if (!rst_n) abort = 1; end
                par = tx;
`endif
                repeat (BD) begin @(negedge clk); if (!rst_n) abort = 1; end
                sp = tx;
                if (!abort) begin
                    check("frame_start_bit", st, 1'b0);
                    check("frame_stop_bit", sp, 1'b1);
`ifdef BLE_CMD_SEQ_PARITY_EN
                    check("frame_parity", par, ^d);
`endif
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %0h expected none", d);
                    end else begin
                        $display("frame decoded %0h parity %0b", d, par);
                        check("frame_data", d, exp_q.pop_front());
                    end
                end
            end
            prev_tx = tx;
        end
    end

    initial begin : stim
        int n, rise, base;
        bit timeout, low_seen;
        rst_n = 0; wr_en = 0; wr_data = 0; flush = 0; enable = 1;
        rst1_n = 0; wr1_en = 0; wr1_data = 0; flush1 = 0; en1 = 1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);       check("rst_full", full, 0);
        check("rst_empty", empty, 1); check("rst_count", count, 0);
        check("rst_busy", busy, 0);   check("rst_cmd_sent", cmd_sent, 0);
        check("rst_ovfl", ovfl, 0);
        rst_n = 1; rst1_n = 1;
        @(negedge clk);

        // Single byte: latency, bit timing, frame length
        exp_q.push_back(8'hA5);
        wr(8'hA5);
        check("t1_tx_at_n", tx, 1);
        @(negedge clk);
        check("t1_tx_at_n1", tx, 1);
        check("t1_busy_load", busy, 1);
        @(negedge clk);
        check("t1_tx_falls_n2", tx, 0);
        n = 0; rise = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (rise == 0 && tx) rise = k;
            if (cmd_sent) begin n = k; break; end
        end
        check("t1_start_bit_len", rise, BD);
        check("t1_cmd_sent_delay", n, FRAME_BITS * BD);
        check("t1_busy_after", busy, 0);

        // Fill to full, overflow, then drain in order
        enable = 0;
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        check("t2_full", full, 1);
        check("t2_count", count, 4);
        check("t2_ovfl_clear", ovfl, 0);
        wr(8'h55);
        check("t2_ovfl_set", ovfl, 1);
        check("t2_count_after_ovfl", count, 4);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        enable = 1;
        timeout = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cmd_sent) begin timeout = 0; break; end
        end
        check("t2_first_sent_timeout", timeout, 0);
        n = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (!tx) begin n = k; break; end
        end
        check("t2_b2b_high_gap", n, 2);
        timeout = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (empty && !busy) begin timeout = 0; break; end
        end
        check("t2_drain_timeout", timeout, 0);
        check("t2_ovfl_sticky", ovfl, 1);

        // Flush with three entries behind the frame in flight
        enable = 0;
        wr(8'h66); wr(8'h77); wr(8'h88); wr(8'h99);
        exp_q.push_back(8'h66);
        enable = 1;
        timeout = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) begin timeout = 0; break; end
        end
        check("t3_start_timeout", timeout, 0);
        @(negedge clk);
        check("t3_count_before_flush", count, 3);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("t3_count_flushed", count, 0);
        check("t3_ovfl_flushed", ovfl, 0);
        check("t3_empty_flushed", empty, 1);
        timeout = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy) begin timeout = 0; break; end
        end
        check("t3_finish_timeout", timeout, 0);
        low_seen = 0;
        repeat (300) begin @(negedge clk); if (!tx || busy) low_seen = 1; end
        check("t3_no_more_frames", low_seen, 0);

        // Reset in the middle of a data bit
        wr(8'hC3); wr(8'h3C);
        timeout = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!tx) begin timeout = 0; break; end
        end
        check("t4_start_timeout", timeout, 0);
        repeat (3 * BD + BD/2) @(negedge clk);
        base = sent_cnt;
        rst_n = 0;
        @(negedge clk);
        check("t4_rst_tx", tx, 1);
        check("t4_rst_count", count, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_cmd_sent", cmd_sent, 0);
        rst_n = 1;
        low_seen = 0;
        repeat (300) begin @(negedge clk); if (!tx) low_seen = 1; end
        check("t4_tx_idle_after", low_seen, 0);
        check("t4_no_cmd_sent", sent_cnt, base);

`ifdef BLE_CMD_SEQ_PARITY_EN
        exp_q.push_back(8'h07); exp_q.push_back(8'h03);
        wr(8'h07); wr(8'h03);
        timeout = 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (empty && !busy) begin timeout = 0; break; end
        end
        check("t5_parity_drain_timeout", timeout, 0);
`endif

        // Programmable gap on the second instance
        wr1_en = 1; wr1_data = 8'h5A;
        @(negedge clk);
        wr1_data = 8'hF0;
        @(negedge clk);
        wr1_en = 0;
        timeout = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cmd_sent1) begin timeout = 0; break; end
        end
        check("t6_first_sent_timeout", timeout, 0);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (!tx1) begin n = k; break; end
        end
        check("t6_gap_high_len", n, 102);
        timeout = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (cmd_sent1) begin timeout = 0; break; end
        end
        check("t6_second_sent_timeout", timeout, 0);

        // Scoreboard must be drained; pulse count matches completed frames
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
        check("sb_queue_empty", exp_q.size(), 0);
`ifdef BLE_CMD_SEQ_PARITY_EN
        check("total_cmd_sent", sent_cnt, 8);
`else
        check("total_cmd_sent", sent_cnt, 6);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ble_cmd_sequencer.md
Name: ble_cmd_sequencer

Overview:
Synthesizable, parametrised successor to the single-shot UART_tx command path used to mimic the BLE module.
- Buffers up to DEPTH host commands in a FIFO.
- Serialises them back-to-back on TX (8N1, LSB first) with a programmable idle gap between frames.
- Pulses cmd_sent per completed frame.
- Sits between a host/stimulus source and the Segway RX pin; drop-in replacement wherever UART_tx drove RX.

Parameters:
- DATA_W, 8, command width in bits (data bits per frame).
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- BAUD_DIV, 2604, clk cycles per bit (19200 baud at 50 MHz); ≥4.
- GAP_CYC, 0, idle cycles (TX=1) inserted after each stop bit before the next start bit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- wr_en  in  1  push wr_data into FIFO this cycle.
- wr_data  in  DATA_W  command to queue.
- flush  in  1  empty FIFO and clear ovfl; frame in flight completes.
- enable  in  1  permits starting a new frame; an in-flight frame always completes.
- TX  out  1  serial output, idle high.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- count  out  $clog2(DEPTH+1)  entries queued (excludes frame in flight).
- busy  out  1  state!=IDLE.
- cmd_sent  out  1  one-cycle pulse at end of each stop bit.
- ovfl  out  1  sticky; set when wr_en while full.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous, active-low.
- Reset values (all registered):
  - TX=1, full=0, empty=1, count=0, busy=0, cmd_sent=0, ovfl=0.
  - FSM=IDLE, all counters 0.
  - Reset mid-frame aborts the frame: TX=1 on the next edge, queue discarded, no cmd_sent.
- FIFO:
  - Write when wr_en && !full.
  - full/empty are based on count at the start of the cycle. A write while full is dropped and sets ovfl, even if a pop occurs the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- flush:
  - Sets count=0 and ovfl=0.
  - Has priority over a same-cycle wr_en, which is discarded without setting ovfl.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE -> LOAD when !empty && enable. Pops the head entry.
  - LOAD (1 cycle): shift reg <= {1'b1 stop, data, 1'b0 start}; baud_cnt=0; bit_cnt=0. Transitions to SHIFT.
  - SHIFT: TX=shift[0]. baud_cnt counts 0..BAUD_DIV-1; at terminal count it shifts right (filling with 1) and increments bit_cnt. After DATA_W+2 bits, assert cmd_sent for one cycle, then go to GAP if GAP_CYC>0, else IDLE.
  - GAP: TX=1 for GAP_CYC cycles, then IDLE.
- Latency:
  - wr_en at edge N into an empty, idle block: LOAD at N+1, TX falls at N+2.
  - Each bit lasts exactly BAUD_DIV cycles.
  - Frame = (DATA_W+2)·BAUD_DIV cycles.
  - Back-to-back frames with GAP_CYC=0 have a 2-cycle TX-high gap (IDLE+LOAD) between the stop bit and the next start bit.
- enable deasserted mid-frame: the frame finishes and the FSM holds in IDLE.
- TX driven from a flop (glitch-free).

Optional Feature:
- Macro: BLE_CMD_SEQ_PARITY_EN.
- Defined: an even-parity bit is inserted between the MSB and the stop bit. The frame becomes DATA_W+3 bits and the shift register widens by 1.
- Undefined: plain 8N1, no parity logic present.

Decomposition:
- Package ble_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} seq_state_t;
  - localparam FRAME_BITS, derived from DATA_W and the parity macro.
- One natural sub-module: ble_cmd_fifo (DEPTH×DATA_W, push/pop/flush, count/full/empty/ovfl).
- FSM and shifter stay in the top level.

Test Plan:
- Single byte, BAUD_DIV=16, GAP_CYC=0, wr_data=8'hA5:
  - TX=0 for 16 cycles starting 2 cycles after write.
  - Then 1,0,1,0,0,1,0,1 at 16 cycles each, then stop bit=1.
  - cmd_sent pulse 160 cycles after TX falls; busy then drops.
- Queue 4 bytes 11,22,33,44 with DEPTH=4:
  - full=1 after 4th write; ovfl stays 0.
  - A 5th write of 55 sets ovfl=1, and 55 is never transmitted.
  - Frames decode as 11,22,33,44 in order (ovfl sticky); 4 cmd_sent pulses.
- GAP_CYC=100, two queued bytes: TX-high interval between stop-bit end and the next start bit = 102 cycles.
- After the first frame starts, assert flush with 3 entries queued:
  - The current frame completes and count=0.
  - No further frames; ovfl cleared.
- Assert rst_n=0 mid-data-bit of a frame: next edge TX=1, count=0, busy=0, no cmd_sent; after release, TX stays 1.
- BLE_CMD_SEQ_PARITY_EN defined:
  - 8'h07 → parity bit 1; 8'h03 → parity bit 0.
  - Frame length 11·BAUD_DIV.
